ook_packet_decoder: RTL and testbench



---
 rtl/ook_packet_decoder.sv | 133 +++++++++++++
 tb/tb_ook_packet_decoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ook_packet_decoder.sv
// ook_packet_decoder: recovers pulse-width-encoded OOK packets from demodulated baseband
// Ports: clk, reset (sync, active-high), ook_in (async OOK, high = carrier),
//        packet_data (last packet, first bit in MSB), packet_valid (1-cycle strobe),
//        repeat_count (consecutive identical packets, saturating), error (1-cycle strobe),
//        busy (high while receiving a packet)
module ook_packet_decoder #(
  parameter int PacketBits   = 32,
  parameter int ShortMin     = 3000,
  parameter int ShortMax     = 6600,
  parameter int LongMin      = 7200,
  parameter int LongMax      = 12000,
  parameter int LowMax       = 12000,
  parameter int GapCycles    = 60000,
  parameter int RepeatWindow = 240000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ook_in,
  output logic [PacketBits-1:0] packet_data,
  output logic                  packet_valid,
  output logic [7:0]            repeat_count,
  output logic                  error,
  output logic                  busy
);
  localparam int BW = $clog2(PacketBits + 1);
  localparam logic [17:0] SMIN = 18'(ShortMin);
  localparam logic [17:0] SMAX = 18'(ShortMax);
  localparam logic [17:0] LMIN = 18'(LongMin);
  localparam logic [17:0] LMAX = 18'(LongMax);
  localparam logic [17:0] LOWM = 18'(LowMax);
  localparam logic [17:0] GAP  = 18'(GapCycles);
  localparam logic [17:0] RWIN = 18'(RepeatWindow);
  localparam logic [BW-1:0] NBITS = BW'(PacketBits);
  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q;
  logic [17:0] cnt_q, cnt_d, since_q, since_d;
  logic [BW-1:0] bits_q, bits_d;
  logic [PacketBits-1:0] sh_q, sh_d, data_q, data_d;
  logic [7:0] rep_q, rep_d;
  logic valid_q, valid_d, err_q, err_d;
  logic rise, fall, is0, is1;
  assign packet_data  = data_q;
  assign packet_valid = valid_q;
  assign repeat_count = rep_q;
  assign error        = err_q;
  assign busy         = (state_q == HIGH) || (state_q == LOW);
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      since_q <= '1;
      bits_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= ook_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      since_q <= since_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    rise    = s2_q & ~s3_q;
    fall    = ~s2_q & s3_q;
    is0     = (cnt_q >= SMIN) && (cnt_q <= SMAX);
    is1     = (cnt_q >= LMIN) && (cnt_q <= LMAX);
    // cnt_q equals the width of the level that just ended on an edge cycle
    cnt_d   = (rise || fall) ? 18'd1 : (&cnt_q ? cnt_q : cnt_q + 18'd1);
    since_d = &since_q ? since_q : since_q + 18'd1;
    state_d = state_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rep_d   = rep_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:  state_d = (!s2_q && !s3_q && cnt_q >= GAP) ? ARMED : IDLE;
      ARMED: if (rise) begin
        state_d = HIGH;
        bits_d  = '0;
        sh_d    = '0;
      end
      HIGH: if (fall) begin
        if ((is0 || is1) && bits_q != NBITS) begin
          sh_d    = {sh_q[PacketBits-2:0], is1};
          bits_d  = bits_q + BW'(1);
          state_d = LOW;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end else if (cnt_q > LMAX) begin
        // carrier stuck on: give up without waiting for the falling edge
        err_d   = 1'b1;
        state_d = IDLE;
      end
      LOW: if (rise) begin
        err_d   = cnt_q > LOWM;
        state_d = (cnt_q > LOWM) ? IDLE : HIGH;
      end else if (cnt_q >= GAP) begin
        // the terminating gap doubles as the arming gap for the next packet
        state_d = ARMED;
        if (bits_q == NBITS) begin
          valid_d = 1'b1;
          data_d  = sh_q;
          since_d = '0;
          // since_q lags the strobe-to-strobe distance by one cycle here
          rep_d   = (sh_q == data_q && rep_q != 8'd0 && since_q < RWIN) ?
                    (&rep_q ? rep_q : rep_q + 8'd1) : 8'd1;
        end else begin
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ook_packet_decoder.sv
// tb_ook_packet_decoder: directed bench with a delivery scoreboard for ook_packet_decoder
module tb_ook_packet_decoder;
  localparam int PB = 32, SMIN = 15, SMAX = 33, LMIN = 36, LMAX = 60, LOWM = 60;
  localparam int GAP = 300, RW = 3000;
  localparam int T0 = 24, T1 = 48, TL = 24;
  typedef struct packed {logic [31:0] d; logic [7:0] r;} exp_t;
  logic clk = 1'b0, reset = 1'b1, ook_in = 1'b0;
  logic [PB-1:0] packet_data;
  logic packet_valid, error, busy;
  logic [7:0] repeat_count;
  exp_t q[$];
  exp_t en, ex;
  int tests = 0, fails = 0, errs = 0, valids = 0, e0;
  ook_packet_decoder #(
    .PacketBits(PB), .ShortMin(SMIN), .ShortMax(SMAX), .LongMin(LMIN), .LongMax(LMAX),
    .LowMax(LOWM), .GapCycles(GAP), .RepeatWindow(RW)
  ) dut (
    .clk(clk), .reset(reset), .ook_in(ook_in), .packet_data(packet_data),
    .packet_valid(packet_valid), .repeat_count(repeat_count), .error(error), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (error) errs++;
    if (packet_valid) begin
      valids++;
      chk("valid_expected", 32'(q.size() != 0), 32'd1);
      chk("valid_error_excl", 32'(error), 32'd0);
      if (q.size() != 0) begin
        ex = q.pop_front();
        chk("data", packet_data, ex.d);
        chk("repeat", 32'(repeat_count), 32'(ex.r));
      end
    end
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input int w);
    ook_in = 1'b1;
    wait_n(w);
    ook_in = 1'b0;
  endtask
  task automatic send(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      pulse(d[31-i] ? T1 : T0);
      if (i != n - 1) wait_n(TL);
    end
  endtask
  task automatic pkt(input logic [31:0] d, input logic [7:0] r);
    en.d = d;
    en.r = r;
    q.push_back(en);
    send(d, 32);
    wait_n(GAP + 20);
    chk("delivered", 32'(q.size()), 32'd0);
  endtask
  initial begin
    wait_n(5);
    reset = 1'b0;
    wait_n(350);
    chk("rst_data", packet_data, 32'd0);
    chk("rst_repeat", 32'(repeat_count), 32'd0);
    chk("rst_valid", 32'(packet_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    pkt(32'hA5C30F71, 8'd1);
    chk("single_noerr", 32'(errs), 32'd0);
    for (int i = 1; i <= 5; i++) pkt(32'h12345678, 8'(i));
    pkt(32'hA5C30F71, 8'd1);
    wait_n(RW);
    pkt(32'hA5C30F71, 8'd1);
    chk("burst_noerr", 32'(errs), 32'd0);
    e0 = errs;
    pulse(34);
    wait_n(2);
    chk("deadband_err_early", 32'(error), 32'd0);
    wait_n(1);
    chk("deadband_err", 32'(error), 32'd1);
    chk("deadband_idle", 32'(busy), 32'd0);
    wait_n(GAP + 20);
    chk("deadband_count", 32'(errs - e0), 32'd1);
    e0 = errs;
    send(32'h0F0F0F0F, 31);
    wait_n(GAP + 20);
    chk("short_packet", 32'(errs - e0), 32'd1);
    e0 = errs;
    send(32'hCAFEBABE, 10);
    wait_n(100);
    pulse(T0);
    wait_n(GAP + 20);
    chk("long_low", 32'(errs - e0), 32'd1);
    e0 = errs;
    send(32'h13572468, 32);
    wait_n(TL);
    pulse(T0);
    wait_n(GAP + 20);
    chk("pulse_33", 32'(errs - e0), 32'd1);
    e0 = errs;
    en.d = 32'h5A5A5A5A;
    en.r = 8'd1;
    q.push_back(en);
    pulse(SMIN);
    wait_n(LOWM);
    pulse(LMAX);
    wait_n(TL);
    for (int i = 2; i < 32; i++) begin
      pulse(en.d[31-i] ? T1 : T0);
      if (i != 31) wait_n(TL);
    end
    wait_n(GAP + 20);
    chk("bound_delivered", 32'(q.size()), 32'd0);
    chk("bound_noerr", 32'(errs - e0), 32'd0);
    e0 = errs;
    pulse(SMIN - 1);
    wait_n(GAP + 20);
    chk("pulse_too_short", 32'(errs - e0), 32'd1);
    e0 = errs;
    pulse(LMAX + 1);
    wait_n(GAP + 20);
    chk("pulse_too_long", 32'(errs - e0), 32'd1);
    send(32'hA5C30F71, 16);
    wait_n(5);
    reset = 1'b1;
    wait_n(1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(packet_valid), 32'd0);
    chk("rst_mid_data", packet_data, 32'd0);
    reset = 1'b0;
    wait_n(GAP + 20);
    pkt(32'hA5C30F71, 8'd1);
    chk("valid_total", 32'(valids), 32'd10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
